// File: rtl/temp_bcd_encoder_pkg.sv
// Shared types and constants for the binary-to-BCD temperature encoder.
package temp_bcd_encoder_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SHIFT   = 2'd1,
        PENDING = 2'd2
    } state_t;

    localparam int unsigned BCD_DIGITS = 3;
    localparam int unsigned NIBBLE_W   = 4;
    localparam int unsigned BCD_W      = BCD_DIGITS * NIBBLE_W;
    localparam int unsigned BCD_MAX    = 999;

    // Three BCD digits as they sit in the double-dabble accumulator.
    typedef struct packed {
        logic [NIBBLE_W-1:0] hundreds;
        logic [NIBBLE_W-1:0] tens;
        logic [NIBBLE_W-1:0] ones;
    } bcd_t;

    localparam bcd_t BCD_SAT = '{hundreds: 4'd9, tens: 4'd9, ones: 4'd9};

endpackage

// File: rtl/temp_bcd_encoder_add3.sv
// Double-dabble nibble correction: add 3 to any digit of 5 or more before a shift.
module bcd_add3_nibble
    import temp_bcd_encoder_pkg::*;
(
    input  logic [NIBBLE_W-1:0] digit,
    output logic [NIBBLE_W-1:0] corrected_c
);

    // Pre-shift correction so the doubled digit carries cleanly into the next nibble.
    always_comb begin
        corrected_c = (digit >= NIBBLE_W'(5)) ? digit + NIBBLE_W'(3) : digit;
    end

endmodule

// File: rtl/temp_bcd_encoder.sv
// Iterative binary-to-BCD converter with valid/ready input and optional frame-aligned commit.
module temp_bcd_encoder
    import temp_bcd_encoder_pkg::*;
#(
    parameter int unsigned BIN_WIDTH     = 8,
    parameter bit          SYNC_TO_FRAME = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [BIN_WIDTH-1:0] sample_bin,
    input  logic                 sample_valid,
    output logic                 sample_ready,
    input  logic                 frame_sync,
    output logic [3:0]           temp_value_100,
    output logic [3:0]           temp_value_10,
    output logic [3:0]           temp_value_1,
    output logic                 overflow,
    output logic                 update_done
);

    localparam int unsigned CNT_W = $clog2(BIN_WIDTH + 1);

    state_t               state, state_next;
    logic [BIN_WIDTH-1:0] shift_reg, shift_next;
    bcd_t                 bcd_reg, bcd_next, bcd_corr;
    logic [CNT_W-1:0]     cnt, cnt_next;
    logic                 ovf_stage, ovf_stage_next;
    logic                 accept_c;
    logic                 commit_c;

    bcd_add3_nibble u_add3_100 (.digit(bcd_reg.hundreds), .corrected_c(bcd_corr.hundreds));
    bcd_add3_nibble u_add3_10  (.digit(bcd_reg.tens),     .corrected_c(bcd_corr.tens));
    bcd_add3_nibble u_add3_1   (.digit(bcd_reg.ones),     .corrected_c(bcd_corr.ones));

    // Next-state, shift datapath and commit decision.
    always_comb begin
        state_next     = state;
        shift_next     = shift_reg;
        bcd_next       = bcd_reg;
        cnt_next       = cnt;
        ovf_stage_next = ovf_stage;
        commit_c       = 1'b0;
        accept_c       = sample_valid && sample_ready;

        case (state)
            IDLE: begin
            end
            SHIFT: begin
                if (cnt != '0) begin
                    bcd_next   = bcd_t'({bcd_corr[BCD_W-2:0], shift_reg[BIN_WIDTH-1]});
                    shift_next = {shift_reg[BIN_WIDTH-2:0], 1'b0};
                    cnt_next   = cnt - CNT_W'(1);
                    // Out-of-range samples saturate on the last shift so staging never holds junk.
                    if ((cnt == CNT_W'(1)) && ovf_stage) begin
                        bcd_next = BCD_SAT;
                    end
                end else if (SYNC_TO_FRAME) begin
                    state_next = PENDING;
                end else begin
                    commit_c   = 1'b1;
                    state_next = IDLE;
                end
            end
            PENDING: begin
                if (frame_sync) begin
                    commit_c   = 1'b1;
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        // A new sample always wins; in PENDING this discards the uncommitted result.
        if (accept_c) begin
            shift_next     = sample_bin;
            bcd_next       = '0;
            cnt_next       = CNT_W'(BIN_WIDTH);
            ovf_stage_next = (32'(sample_bin) > BCD_MAX);
            state_next     = SHIFT;
        end
    end

    // State and staging registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            shift_reg <= '0;
            bcd_reg   <= '0;
            cnt       <= '0;
            ovf_stage <= 1'b0;
        end else begin
            state     <= state_next;
            shift_reg <= shift_next;
            bcd_reg   <= bcd_next;
            cnt       <= cnt_next;
            ovf_stage <= ovf_stage_next;
        end
    end

    // Committed display outputs, update pulse and ready flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            temp_value_100 <= '0;
            temp_value_10  <= '0;
            temp_value_1   <= '0;
            overflow       <= 1'b0;
            update_done    <= 1'b0;
            sample_ready   <= 1'b1;
        end else begin
            update_done  <= commit_c;
            sample_ready <= (state_next != SHIFT);
            if (commit_c) begin
                temp_value_100 <= bcd_reg.hundreds;
                temp_value_10  <= bcd_reg.tens;
                temp_value_1   <= bcd_reg.ones;
                overflow       <= ovf_stage;
            end
        end
    end

endmodule

// File: tb/tb_temp_bcd_encoder.sv
// Self-checking bench: three encoder configurations, scoreboard of expected committed digits.
module tb_temp_bcd_encoder;

    logic       clk;
    logic       rst_n;
    logic [7:0] bin_a, bin_b;
    logic [9:0] bin_c;
    logic [2:0] valid, fsync, rdy, upd, ovf;
    logic [2:0][3:0] d100, d10, d1;

    int checks;
    int failures;
    logic [12:0] sb[$];

    // 0: BIN_WIDTH=8 immediate commit, 1: BIN_WIDTH=8 frame-synced, 2: BIN_WIDTH=10 immediate
    temp_bcd_encoder #(.BIN_WIDTH(8), .SYNC_TO_FRAME(1'b0)) u_imm (
        .clk(clk), .rst_n(rst_n), .sample_bin(bin_a), .sample_valid(valid[0]),
        .sample_ready(rdy[0]), .frame_sync(fsync[0]), .temp_value_100(d100[0]),
        .temp_value_10(d10[0]), .temp_value_1(d1[0]), .overflow(ovf[0]), .update_done(upd[0]));

    temp_bcd_encoder #(.BIN_WIDTH(8), .SYNC_TO_FRAME(1'b1)) u_frm (
        .clk(clk), .rst_n(rst_n), .sample_bin(bin_b), .sample_valid(valid[1]),
        .sample_ready(rdy[1]), .frame_sync(fsync[1]), .temp_value_100(d100[1]),
        .temp_value_10(d10[1]), .temp_value_1(d1[1]), .overflow(ovf[1]), .update_done(upd[1]));

    temp_bcd_encoder #(.BIN_WIDTH(10), .SYNC_TO_FRAME(1'b0)) u_w10 (
        .clk(clk), .rst_n(rst_n), .sample_bin(bin_c), .sample_valid(valid[2]),
        .sample_ready(rdy[2]), .frame_sync(fsync[2]), .temp_value_100(d100[2]),
        .temp_value_10(d10[2]), .temp_value_1(d1[2]), .overflow(ovf[2]), .update_done(upd[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: decimal digits by division, saturating at 999. Packed {ovf, h, t, o}.
    function automatic logic [12:0] model(input int v);
        int w;
        logic sat;
        sat = (v > 999);
        w   = sat ? 999 : v;
        return {sat, 4'(w / 100), 4'((w / 10) % 10), 4'(w % 10)};
    endfunction

    function automatic logic [12:0] obs(input int d);
        return {ovf[d], d100[d], d10[d], d1[d]};
    endfunction

    // Present one sample for a single edge; caller ensures ready. Returns at the negedge after accept.
    task automatic drive_sample(input int d, input int v);
        case (d)
            0:       bin_a = 8'(v);
            1:       bin_b = 8'(v);
            default: bin_c = 10'(v);
        endcase
        valid[d] = 1'b1;
        sb.push_back(model(v));
        @(negedge clk);
        valid[d] = 1'b0;
    endtask

    task automatic wait_cycles(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    // Count negedges until update_done; -1 on timeout.
    task automatic wait_upd(input int d, input int max, output int cyc);
        cyc = -1;
        for (int k = 1; k <= max; k++) begin
            @(negedge clk);
            if (upd[d]) begin
                cyc = k;
                break;
            end
        end
    endtask

    task automatic pulse_fsync(input int d);
        fsync[d] = 1'b1;
        @(negedge clk);
        fsync[d] = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        wait_cycles(2);
        for (int d = 0; d < 3; d++) begin
            checks++;
            if (obs(d) !== 13'h0) begin
                failures++;
                $display("FAIL reset_digits[%0d]: got %h want 0", d, obs(d));
            end
            checks++;
            if (upd[d] !== 1'b0) begin
                failures++;
                $display("FAIL reset_update_done[%0d]: got %b want 0", d, upd[d]);
            end
        end
        rst_n = 1'b1;
        @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            checks++;
            if (rdy[d] !== 1'b1) begin
                failures++;
                $display("FAIL reset_ready[%0d]: got %b want 1", d, rdy[d]);
            end
        end
    endtask

    task automatic test_immediate;
        logic [12:0] exp;
        bit ready_low_ok;
        sb.delete();
        drive_sample(0, 173);
        ready_low_ok = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (rdy[0] !== 1'b0 || upd[0] !== 1'b0) ready_low_ok = 1'b0;
        end
        checks++;
        if (!ready_low_ok) begin
            failures++;
            $display("FAIL imm_busy_window: ready/update_done not 0 over edges N+1..N+8 got 0 want 1");
        end
        @(negedge clk);
        checks++;
        if (upd[0] !== 1'b1) begin
            failures++;
            $display("FAIL imm_update_at_n9: got %b want 1", upd[0]);
        end
        exp = sb.pop_front();
        checks++;
        if (obs(0) !== exp) begin
            failures++;
            $display("FAIL imm_digits_173: got %h want %h", obs(0), exp);
        end
        @(negedge clk);
        checks++;
        if (upd[0] !== 1'b0 || obs(0) !== exp || rdy[0] !== 1'b1) begin
            failures++;
            $display("FAIL imm_after_commit: got upd=%b rdy=%b dig=%h want upd=0 rdy=1 dig=%h",
                     upd[0], rdy[0], obs(0), exp);
        end
    endtask

    task automatic test_boundaries;
        int vals[6] = '{0, 9, 10, 99, 100, 255};
        int cyc;
        logic [12:0] exp;
        sb.delete();
        foreach (vals[i]) begin
            drive_sample(0, vals[i]);
            wait_upd(0, 20, cyc);
            checks++;
            if (cyc != 9) begin
                failures++;
                $display("FAIL bound_latency_%0d: got %0d want 9", vals[i], cyc);
            end
            exp = (sb.size() != 0) ? sb.pop_front() : 13'h1fff;
            checks++;
            if (obs(0) !== exp) begin
                failures++;
                $display("FAIL bound_digits_%0d: got %h want %h", vals[i], obs(0), exp);
            end
        end
    endtask

    task automatic test_reset_mid_shift;
        bit no_upd;
        sb.delete();
        drive_sample(0, 200);
        wait_cycles(3);
        rst_n = 1'b0;
        #1;
        checks++;
        if (obs(0) !== 13'h0) begin
            failures++;
            $display("FAIL midrst_async_clear: got %h want 0", obs(0));
        end
        wait_cycles(3);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (rdy[0] !== 1'b1) begin
            failures++;
            $display("FAIL midrst_ready: got %b want 1", rdy[0]);
        end
        no_upd = 1'b1;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (upd[0] !== 1'b0 || obs(0) !== 13'h0) no_upd = 1'b0;
        end
        checks++;
        if (!no_upd) begin
            failures++;
            $display("FAIL midrst_no_update: got spurious commit want none");
        end
    endtask

    task automatic test_frame_sync;
        logic [12:0] exp;
        bit held;
        sb.delete();
        drive_sample(1, 65);
        wait_cycles(10);
        checks++;
        if (rdy[1] !== 1'b1 || upd[1] !== 1'b0 || obs(1) !== 13'h0) begin
            failures++;
            $display("FAIL frm_pending_hold: got rdy=%b upd=%b dig=%h want 1 0 000", rdy[1], upd[1], obs(1));
        end
        pulse_fsync(1);
        exp = sb.pop_front();
        checks++;
        if (upd[1] !== 1'b1 || obs(1) !== exp) begin
            failures++;
            $display("FAIL frm_commit_65: got upd=%b dig=%h want 1 %h", upd[1], obs(1), exp);
        end
        @(negedge clk);
        checks++;
        if (upd[1] !== 1'b0) begin
            failures++;
            $display("FAIL frm_pulse_width: got %b want 0", upd[1]);
        end
        drive_sample(1, 72);
        wait_cycles(3);
        pulse_fsync(1);
        held = 1'b1;
        for (int k = 0; k < 8; k++) begin
            if (upd[1] !== 1'b0 || obs(1) !== exp) held = 1'b0;
            @(negedge clk);
        end
        checks++;
        if (!held || rdy[1] !== 1'b1) begin
            failures++;
            $display("FAIL frm_sync_in_shift_ignored: got held=%b rdy=%b dig=%h want 1 1 %h",
                     held, rdy[1], obs(1), exp);
        end
        pulse_fsync(1);
        exp = sb.pop_front();
        checks++;
        if (upd[1] !== 1'b1 || obs(1) !== exp) begin
            failures++;
            $display("FAIL frm_commit_72: got upd=%b dig=%h want 1 %h", upd[1], obs(1), exp);
        end
    endtask

    task automatic test_replace;
        logic [12:0] exp;
        bit never72;
        sb.delete();
        drive_sample(1, 33);
        wait_cycles(10);
        pulse_fsync(1);
        exp = sb.pop_front();
        checks++;
        if (upd[1] !== 1'b1 || obs(1) !== exp) begin
            failures++;
            $display("FAIL repl_commit_33: got upd=%b dig=%h want 1 %h", upd[1], obs(1), exp);
        end
        drive_sample(1, 72);
        wait_cycles(10);
        sb.delete();
        never72 = 1'b1;
        drive_sample(1, 80);
        for (int k = 0; k < 10; k++) begin
            if (upd[1] !== 1'b0 || obs(1) !== exp) never72 = 1'b0;
            @(negedge clk);
        end
        checks++;
        if (!never72) begin
            failures++;
            $display("FAIL repl_discard_72: got dig=%h want %h held", obs(1), exp);
        end
        pulse_fsync(1);
        exp = sb.pop_front();
        checks++;
        if (upd[1] !== 1'b1 || obs(1) !== exp) begin
            failures++;
            $display("FAIL repl_commit_80: got upd=%b dig=%h want 1 %h", upd[1], obs(1), exp);
        end
    endtask

    task automatic test_back_to_back_commit_accept;
        logic [12:0] exp;
        sb.delete();
        drive_sample(1, 50);
        wait_cycles(10);
        bin_b    = 8'd61;
        valid[1] = 1'b1;
        fsync[1] = 1'b1;
        sb.push_back(model(61));
        @(negedge clk);
        valid[1] = 1'b0;
        fsync[1] = 1'b0;
        exp = sb.pop_front();
        checks++;
        if (upd[1] !== 1'b1 || obs(1) !== exp || rdy[1] !== 1'b0) begin
            failures++;
            $display("FAIL b2b_commit_and_accept: got upd=%b rdy=%b dig=%h want 1 0 %h",
                     upd[1], rdy[1], obs(1), exp);
        end
        wait_cycles(10);
        pulse_fsync(1);
        exp = sb.pop_front();
        checks++;
        if (upd[1] !== 1'b1 || obs(1) !== exp) begin
            failures++;
            $display("FAIL b2b_commit_61: got upd=%b dig=%h want 1 %h", upd[1], obs(1), exp);
        end
    endtask

    task automatic test_overflow;
        int vals[4] = '{1023, 998, 999, 1000};
        int cyc;
        logic [12:0] exp;
        sb.delete();
        foreach (vals[i]) begin
            drive_sample(2, vals[i]);
            wait_upd(2, 24, cyc);
            checks++;
            if (cyc != 11) begin
                failures++;
                $display("FAIL ovf_latency_%0d: got %0d want 11", vals[i], cyc);
            end
            exp = (sb.size() != 0) ? sb.pop_front() : 13'h1fff;
            checks++;
            if (obs(2) !== exp) begin
                failures++;
                $display("FAIL ovf_digits_%0d: got %h want %h", vals[i], obs(2), exp);
            end
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        valid    = '0;
        fsync    = '0;
        bin_a    = '0;
        bin_b    = '0;
        bin_c    = '0;
        test_reset();
        test_immediate();
        test_boundaries();
        test_reset_mid_shift();
        test_frame_sync();
        test_replace();
        test_back_to_back_commit_accept();
        test_overflow();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/temp_bcd_encoder.md
Name: temp_bcd_encoder

Overview:
Converts a binary temperature sample into the three BCD digits (hundreds, tens, ones) consumed by the on-screen temperature digit renderer. It uses an iterative shift-add-3 (double-dabble) datapath with a valid/ready input handshake. Committed digits are held stable between updates. Commits can optionally be deferred to a frame boundary so displayed digits never change mid-frame.

Parameters:
BIN_WIDTH, 8, width of binary sample; legal range 4..10
SYNC_TO_FRAME, 1, 1 = commit new digits only on frame_sync; 0 = commit immediately on conversion end

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
sample_bin  input  BIN_WIDTH  unsigned binary temperature
sample_valid  input  1  sample_bin valid this cycle
sample_ready  output  1  block can accept a sample
frame_sync  input  1  one-cycle pulse at start of vertical blanking
temp_value_100  output  4  committed hundreds digit (BCD)
temp_value_10  output  4  committed tens digit (BCD)
temp_value_1  output  4  committed ones digit (BCD)
overflow  output  1  committed value saturated at 999
update_done  output  1  one-cycle pulse on the edge the outputs change

Behaviour:
- Reset is asynchronous on rst_n low. State goes to IDLE. All digit outputs are 0. overflow=0, update_done=0, shift counter=0, staging registers=0. After reset is released, sample_ready=1.
- States: IDLE, SHIFT, PENDING.
- sample_ready=1 in IDLE and PENDING; 0 in SHIFT.
- A sample is accepted on an edge where sample_valid && sample_ready.
- Accept from IDLE or PENDING:
  - Load sample_bin into the shift register and clear the 12-bit BCD accumulator.
  - Set the staged overflow flag if sample_bin > 999. This is only reachable when BIN_WIDTH=10.
  - Counter = BIN_WIDTH; go to SHIFT.
  - Accepting from PENDING discards the un-committed result. The newest sample wins.
- SHIFT, one cycle per bit:
  - Each BCD nibble >= 5 gets +3.
  - Then shift {bcd, bin} left by 1.
  - Decrement the counter.
  - After BIN_WIDTH cycles the staged digits hold the result.
  - If the staged overflow flag is set, force the staged digits to 9,9,9.
- End of SHIFT:
  - SYNC_TO_FRAME=0: commit on the edge after the last shift cycle (accept edge N → outputs change at edge N+BIN_WIDTH+1), then go to IDLE.
  - SYNC_TO_FRAME=1: go to PENDING.
- PENDING: commit on the first edge with frame_sync=1, then go to IDLE.
  - A frame_sync pulse that arrives while in SHIFT is ignored and not remembered; the commit waits for the next pulse.
- Simultaneous frame_sync and sample_valid in PENDING: commit the pending result (update_done=1) and also accept the new sample into SHIFT.
- Commit actions:
  - temp_value_100/10/1 and overflow load from staging in the same edge.
  - update_done is high for exactly that one cycle.
  - Outputs are otherwise held unchanged.
- Every BCD nibble must stay within 0..9 at all times. No output ever shows a partially converted value.
- sample_bin is don't-care when sample_valid=0, and is not sampled outside the accept edge.

Decomposition:
- Shared package holds:
  - state encoding constants (IDLE=2'd0, SHIFT=2'd1, PENDING=2'd2);
  - BCD_DIGITS=3;
  - BCD_MAX=999.
- One natural sub-module: bcd_add3_nibble, a combinational nibble correction (n>=5 ? n+3 : n), instantiated three times.
- The FSM, counter and commit logic stay in the top module.

Test Plan:
- Reset mid-SHIFT: accept sample_bin=200, assert rst_n low 3 cycles later → digits 0,0,0 immediately; sample_ready=1 after release; no update_done pulse.
- SYNC_TO_FRAME=0, BIN_WIDTH=8: accept 8'd173 at edge N → digits 1,7,3 and update_done=1 at edge N+9; sample_ready=0 for edges N+1..N+8.
- Boundary values at BIN_WIDTH=8: 0 → 0,0,0; 9 → 0,0,9; 10 → 0,1,0; 99 → 0,9,9; 100 → 1,0,0; 255 → 2,5,5.
- SYNC_TO_FRAME=1: accept 72 while the display shows 0,6,5 → digits hold 0,6,5 in PENDING until frame_sync; commit to 0,7,2 on that edge only. A frame_sync during SHIFT causes no commit.
- Replacement in PENDING: 72 pending, then accept 80 before frame_sync → the next frame_sync after conversion shows 0,8,0; 0,7,2 never appears.
- BIN_WIDTH=10 overflow: accept 1023 → digits 9,9,9 with overflow=1. A following sample of 998 → digits 9,9,8 with overflow=0.
